// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding (common to TX and RX) and default sizes.
package uart_pkg;

    localparam int UART_WORD_WIDTH   = 8;
    localparam int UART_OVERSAMPLING = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP_BIT  = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pad plus falling-edge start detect.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_level,
    output logic o_start
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    // Reset to the idle-high line level so reset release never looks like a start edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
        end else begin
            sync_p0 <= i_rx;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign o_level = sync_p1;
    assign o_start = prev_p2 & ~sync_p1;

endmodule

// File: rtl/uart_rx_des.sv
// UART receive deserializer: oversampled mid-bit sampling of start/data/parity/stop,
// delivering each word with odd-parity and framing status.
module uart_rx_des
    import uart_pkg::*;
#(
    parameter int WORD_WIDTH   = UART_WORD_WIDTH,
    parameter int OVERSAMPLING = UART_OVERSAMPLING
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tick,
    input  logic                  i_rx,
    input  logic                  i_parity,
    output logic [WORD_WIDTH-1:0] o_dout,
    output logic                  o_valid,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_active
);

    localparam int TW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(WORD_WIDTH + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLING - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_WIDTH - 1);

    function automatic logic parity_mismatch(input logic [WORD_WIDTH-1:0] data,
                                             input logic                  pbit);
        return pbit != ~^data;
    endfunction

    uart_state_e           state;
    logic [TW-1:0]         tick_ctr;
    logic [BW-1:0]         bit_ctr;
    logic [WORD_WIDTH-1:0] shift_reg;
    logic                  par_en;
    logic                  par_bit;
    logic                  rx_level;
    logic                  start;
    logic                  mid_bit;

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_rx    (i_rx),
        .o_level (rx_level),
        .o_start (start)
    );

    assign mid_bit = i_tick && (tick_ctr == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            tick_ctr     <= '0;
            bit_ctr      <= '0;
            shift_reg    <= '0;
            par_en       <= 1'b0;
            par_bit      <= 1'b0;
            o_dout       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_active     <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_tick && tick_ctr != '0 && state != IDLE)
                tick_ctr <= tick_ctr - TW'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= START_BIT;
                        tick_ctr <= TICK_HALF;
                        par_en   <= i_parity;
                        o_active <= 1'b1;
                    end
                end
                // A start bit that is high again at its centre was only a glitch
                START_BIT: begin
                    if (mid_bit) begin
                        if (!rx_level) begin
                            state    <= DATA;
                            tick_ctr <= TICK_FULL;
                            bit_ctr  <= '0;
                        end else begin
                            state    <= IDLE;
                            o_active <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        shift_reg <= {rx_level, shift_reg[WORD_WIDTH-1:1]};
                        tick_ctr  <= TICK_FULL;
                        bit_ctr   <= bit_ctr + BW'(1);
                        if (bit_ctr == LAST_BIT)
                            state <= par_en ? PARITY : STOP_BIT;
                    end
                end
                PARITY: begin
                    if (mid_bit) begin
                        par_bit  <= rx_level;
                        tick_ctr <= TICK_FULL;
                        state    <= STOP_BIT;
                    end
                end
                // Leave at stop mid-bit so half a bit remains to catch the next start edge
                STOP_BIT: begin
                    if (mid_bit) begin
                        o_dout       <= shift_reg;
                        o_frame_err  <= ~rx_level;
                        o_parity_err <= par_en & parity_mismatch(shift_reg, par_bit);
                        o_valid      <= 1'b1;
                        o_active     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    o_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_des.sv
// Bench for uart_rx_des: vector table, hand-written corner sequences and random frames
// checked against a frame-level model of the serial protocol.
module tb_uart_rx_des;

    localparam int W   = 8;
    localparam int OVS = 16;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_tick = 1'b0;
    logic         i_rx = 1'b1;
    logic         i_parity = 1'b0;
    logic [W-1:0] o_dout;
    logic         o_valid;
    logic         o_parity_err;
    logic         o_frame_err;
    logic         o_active;

    int div = 1;
    int tick_phase = 0;
    int cyc = 0;
    int act_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    int rd_idx = 0;

    typedef struct packed {
        logic [W-1:0] dout;
        logic         perr;
        logic         ferr;
        logic         act;
        logic [31:0]  cyc;
    } rec_t;
    rec_t rxq[$];

    typedef struct {
        logic [W-1:0] data;
        logic         par_en;
        logic         pbit;
        logic         stop;
        int           div;
        logic [W-1:0] exp_dout;
        logic         exp_perr;
        logic         exp_ferr;
    } vec_t;

    uart_rx_des #(.WORD_WIDTH(W), .OVERSAMPLING(OVS)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_tick       (i_tick),
        .i_rx         (i_rx),
        .i_parity     (i_parity),
        .o_dout       (o_dout),
        .o_valid      (o_valid),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_active     (o_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        i_tick = (tick_phase == 0);
        tick_phase = (tick_phase + 1 >= div) ? 0 : tick_phase + 1;
    end

    always @(negedge clk) begin
        if (o_active) act_cnt = act_cnt + 1;
        if (o_valid) rxq.push_back({o_dout, o_parity_err, o_frame_err, o_active, 32'(cyc)});
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        int c = 0;
        i_rx = v;
        while (c < n) begin
            @(posedge clk);
            if (i_tick) c++;
        end
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic par_en,
                              input logic pbit, input logic stop);
        i_parity = par_en;
        hold(1'b0, OVS);
        i_parity = 1'($urandom_range(0, 1));
        for (int i = 0; i < W; i++) hold(data[i], OVS);
        if (par_en) hold(pbit, OVS);
        hold(stop, OVS);
    endtask

    task automatic expect_rx(input string nm, input logic [W-1:0] d,
                             input logic pe, input logic fe);
        int w = 0;
        rec_t r;
        while (rxq.size() <= rd_idx && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (rxq.size() <= rd_idx) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no o_valid within budget, got none, expected one", nm);
        end else begin
            r = rxq[rd_idx];
            rd_idx++;
            check({nm, " dout"}, 32'(r.dout), 32'(d));
            check({nm, " parity_err"}, 32'(r.perr), 32'(pe));
            check({nm, " frame_err"}, 32'(r.ferr), 32'(fe));
            check({nm, " active_at_valid"}, 32'(r.act), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " dout"}, 32'(o_dout), 32'd0);
        check({nm, " valid"}, 32'(o_valid), 32'd0);
        check({nm, " parity_err"}, 32'(o_parity_err), 32'd0);
        check({nm, " frame_err"}, 32'(o_frame_err), 32'd0);
        check({nm, " active"}, 32'(o_active), 32'd0);
    endtask

    initial begin
        vec_t vecs[4];
        int t0, a0, lat;
        logic [W-1:0] d;
        logic pe, pb, st;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 1'b1, 1'b1, 1'b1, 1, 8'h03, 1'b0, 1'b0};
        vecs[2] = '{8'h03, 1'b1, 1'b0, 1'b1, 2, 8'h03, 1'b1, 1'b0};
        vecs[3] = '{8'hE7, 1'b1, 1'b1, 1'b0, 3, 8'hE7, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #1 i_rst = 1'b0;
        hold(1'b1, 4);

        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        expect_rx("basic A5", 8'hA5, 1'b0, 1'b0);
        lat = int'(rxq[rd_idx-1].cyc) - t0;
        n_checks++;
        if (lat < 150 || lat > 162) begin
            n_fail++;
            $display("FAIL basic latency: got %0d cycles, expected 150..162", lat);
        end

        for (int i = 0; i < 4; i++) begin
            div = vecs[i].div;
            send_frame(vecs[i].data, vecs[i].par_en, vecs[i].pbit, vecs[i].stop);
            expect_rx($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_perr, vecs[i].exp_ferr);
            hold(1'b1, 4);
        end

        div = 1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        expect_rx("framing 5A", 8'h5A, 1'b0, 1'b1);
        hold(1'b0, 64);
        check("stuck low valid count", 32'(rxq.size()), 32'(rd_idx));
        check("stuck low active", 32'(o_active), 32'd0);
        hold(1'b1, 4);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        expect_rx("after framing 11", 8'h11, 1'b0, 1'b0);

        a0 = act_cnt;
        hold(1'b0, 3);
        hold(1'b1, 40);
        check("glitch saw active", 32'(act_cnt > a0), 32'd1);
        check("glitch active back low", 32'(o_active), 32'd0);
        check("glitch valid count", 32'(rxq.size()), 32'(rd_idx));

        div = 4;
        hold(1'b1, 2);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        expect_rx("b2b 00", 8'h00, 1'b0, 1'b0);
        expect_rx("b2b FF", 8'hFF, 1'b0, 1'b0);
        expect_rx("b2b 81", 8'h81, 1'b0, 1'b0);

        div = 1;
        hold(1'b1, 4);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        expect_rx("pre-reset 3C", 8'h3C, 1'b1, 1'b1);
        hold(1'b1, 4);
        i_parity = 1'b0;
        hold(1'b0, OVS);
        for (int i = 0; i < 4; i++) hold(d_bit(8'h3C, i), OVS);
        hold(1'b1, OVS / 2);
        i_rst = 1'b1;
        @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid-frame reset");
        hold(1'b1, 200);
        check("reset discards frame", 32'(rxq.size()), 32'(rd_idx));
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        expect_rx("post-reset C3", 8'hC3, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            div = $urandom_range(1, 4);
            hold(1'b1, 2);
            d  = W'($urandom);
            pe = 1'($urandom_range(0, 1));
            pb = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) != 0);
            send_frame(d, pe, pb, st);
            expect_rx($sformatf("rand%0d", k), d,
                      pe && (($countones(d) + int'(pb)) % 2 == 0), !st);
            hold(1'b1, $urandom_range(2, 6));
        end

        hold(1'b1, 40);
        check("no extra o_valid", 32'(rxq.size()), 32'(rd_idx));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic d_bit(input logic [W-1:0] v, input int i);
        return v[i];
    endfunction

endmodule

// File: doc/uart_rx_des.md
# uart_rx_des

UART receive deserializer: converts the asynchronous serial line into parallel words, the receive-side counterpart of the UART transmit serializer. It sits between the pad-level RX input and the UART receive FIFO/register interface. It shares the baud `i_tick` strobe (OVERSAMPLING ticks per bit) with the transmitter. It reports per-word parity and framing status.

## Interface
- `WORD_WIDTH`, 8: data bits per frame, LSB first.
- `OVERSAMPLING`, 16: `i_tick` pulses per bit period; even, ≥4.
- `i_clk`  in  1: clock; all logic on rising edge.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_tick`  in  1: single-cycle oversampling strobe.
- `i_rx`  in  1: asynchronous serial line; idle high.
- `i_parity`  in  1: 1 = frame carries a parity bit after the data bits.
- `o_dout`  out  WORD_WIDTH: received word; held until the next `o_valid`.
- `o_valid`  out  1: one-cycle pulse when `o_dout`/error flags update.
- `o_parity_err`  out  1: parity mismatch for the word in `o_dout`.
- `o_frame_err`  out  1: stop bit sampled low for the word in `o_dout`.
- `o_active`  out  1: high whenever state ≠ IDLE.

## Operation
- Frame format: start (0), WORD_WIDTH data bits LSB first, optional parity, one stop (1).
- Parity is odd: expected parity bit = ~^data. This matches the transmitter.
- `i_rx` passes through a 2-flop synchronizer (reset value 1), then a previous-sample register (reset 1).
- Start detect is a falling edge: synchronized line 0 while previous sample 1. A line stuck low never retriggers.
- States:
  - IDLE: on start edge (tick-independent) → START_BIT, tick_ctr = OVERSAMPLING/2 − 1, latch `i_parity`.
  - START_BIT: on each tick, decrement. At tick_ctr==0 (mid start bit):
    - line 0 → DATA, tick_ctr = OVERSAMPLING−1, bit_ctr = 0.
    - line 1 → IDLE (glitch rejected, no `o_valid`).
  - DATA: at each tick with tick_ctr==0:
    - shift the sampled bit into the MSB of the shift register (right shift); reload tick_ctr.
    - After the WORD_WIDTH-th bit → PARITY if latched parity, else STOP_BIT.
  - PARITY: at mid-bit, capture the parity bit → STOP_BIT, reload tick_ctr.
  - STOP_BIT: at mid-bit, register `o_dout` and errors, pulse `o_valid` → IDLE.
- Receiver returns to IDLE at stop mid-bit, leaving half a bit for resync to the next start.
- `o_parity_err` is 0 when the latched parity is 0.
- A framing error still delivers the data word with `o_frame_err`=1.
- `i_parity` changes mid-frame have no effect until the next start.

## Timing
- Reset values:
  - `o_dout`=0, `o_valid`=0, `o_parity_err`=0, `o_frame_err`=0, `o_active`=0.
  - state=IDLE; synchronizer and previous-sample registers=1; counters=0.
- Input to start-detect latency is 2 `i_clk` cycles (synchronizer) plus 1 cycle (edge register).
- Samples are taken at the tick where tick_ctr==0. `o_valid` rises the `i_clk` cycle after the stop-bit sampling tick and lasts exactly 1 cycle.
- `o_active` rises the cycle after start detect. It falls in the same cycle `o_valid` rises.
- `i_tick` is absent for the cycle(s) between ticks; counters change only on ticks, except the IDLE→START_BIT load.
- `i_rst` mid-frame: next cycle, state=IDLE and all outputs at reset values. The partial frame is discarded with no `o_valid`.
- Back-to-back frames (stop immediately followed by start) are received with no lost word.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START_BIT, DATA, PARITY, STOP_BIT), 3-bit, shared with the TX encoding.
  - default WORD_WIDTH/OVERSAMPLING constants.
- Widths:
  - tick_ctr: $clog2(OVERSAMPLING).
  - bit_ctr: $clog2(WORD_WIDTH+1).
- Sub-module `uart_rx_sync`: 2-flop synchronizer plus falling-edge detect. Outputs are the synchronized level and a start pulse.

## Test plan
- **Basic receive:** reset, i_parity=0, tick every cycle, send 0xA5 → one `o_valid`, `o_dout`=0xA5, both errors 0, ~160 cycles after the start edge.
- **Parity:** i_parity=1.
  - Send 0x03 with parity bit 1 (correct, odd) → `o_parity_err`=0.
  - Repeat with parity bit 0 → `o_dout`=0x03, `o_parity_err`=1.
- **Framing:** send 0x5A with the stop bit driven 0 → `o_dout`=0x5A, `o_frame_err`=1.
  - Hold the line low afterwards → no further `o_valid`.
  - Releasing the line high, then sending 0x11, receives it cleanly.
- **Glitch:** drive `i_rx` low for 3 ticks (< OVERSAMPLING/2) then high → `o_active` returns to 0, no `o_valid`.
- **Back-to-back and slow tick:** tick every 4 cycles, send 0x00, 0xFF, 0x81 consecutively → three `o_valid` pulses in order with matching data.
- **Reset mid-frame:** assert `i_rst` during bit 4 of 0x3C → outputs return to reset values, no `o_valid`. A following frame 0xC3 is received correctly.
